// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with optional return stack.
//
// Purpose: a registered program counter. Each cycle it does one of the
// following: holds, returns from the stack, calls, branches (absolute or
// relative) or increments.
//
// Configuration macro: PC_SEQUENCER_RETURN_STACK_EN
//   defined   - the LIFO return stack plus the call/ret handling and the
//               sticky overflow/underflow flags are built.
//   undefined - call and ret are ignored. stack_depth, overflow and
//               underflow are tied to 0, and no stack storage exists.
//
// Parameters:
//   AW     program-counter / address width in bits (2..32)
//   DEPTH  return-stack entries (1..16)
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous active-high reset (pc <= start_address)
//   start_address    in   AW   pc value loaded on reset
//   halt             in   hold all state
//   branch_enable    in   take a branch this cycle
//   branch_relative  in   1: branch_address is a signed offset from pc
//   branch_address   in   AW   branch target/offset, also the call target
//   call             in   push pc+1 and jump to branch_address
//   ret              in   pop the return stack into pc
//   pc               out  AW   current program counter (registered)
//   stack_depth      out  number of valid stack entries (registered)
//   overflow         out  sticky: call attempted with the stack full
//   underflow        out  sticky: ret attempted with the stack empty
module pc_sequencer #(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [AW-1:0]                start_address,
  input  logic                         halt,
  input  logic                         branch_enable,
  input  logic                         branch_relative,
  input  logic [AW-1:0]                branch_address,
  input  logic                         call,
  input  logic                         ret,
  output logic [AW-1:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_inc;

  assign pc_inc = pc_q + AW'(1);

`ifdef PC_SEQUENCER_RETURN_STACK_EN
  // The index width is kept at least 1 bit so that DEPTH=1 still has a
  // legal index.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] stack_mem [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_en;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;

  assign push_idx = IW'(depth_q);
  assign top_idx  = IW'(depth_q - DW'(1));
`else
  // call and ret have no effect in this build.
  logic unused_stack_inputs;
  assign unused_stack_inputs = call ^ ret;
`endif

  always_comb begin
    pc_d = pc_q;
`ifdef PC_SEQUENCER_RETURN_STACK_EN
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;
`endif
    if (!halt) begin
`ifdef PC_SEQUENCER_RETURN_STACK_EN
      // ret wins over call when both are asserted together.
      if (ret) begin
        if (depth_q != '0) begin
          pc_d    = stack_mem[top_idx];
          depth_d = depth_q - DW'(1);
        end else begin
          underflow_d = 1'b1;
          pc_d        = pc_inc;
        end
      end else if (call) begin
        if (depth_q < DW'(DEPTH)) begin
          push_en = 1'b1;
          depth_d = depth_q + DW'(1);
          pc_d    = branch_address;
        end else begin
          overflow_d = 1'b1;
          pc_d       = pc_inc;
        end
      end else
`endif
      if (branch_enable) begin
        // A relative branch is plain modular addition. An offset with the
        // top bit set therefore moves pc backwards.
        pc_d = branch_relative ? (pc_q + branch_address) : branch_address;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= start_address;
`ifdef PC_SEQUENCER_RETURN_STACK_EN
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
`ifdef PC_SEQUENCER_RETURN_STACK_EN
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`endif
    end
  end

`ifdef PC_SEQUENCER_RETURN_STACK_EN
  // The stack entries are never reset. An entry is only read below
  // depth_q, and reset returns depth_q to zero, so stale data is never
  // returned.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign stack_depth = depth_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
`else
  assign stack_depth = '0;
  assign overflow    = 1'b0;
  assign underflow   = 1'b0;
`endif

  assign pc = pc_q;

endmodule
